// File: rtl/mul_tile_engine.sv
// mul_tile_engine: weight-stationary N x N multiply tile.
//   Loads an N x N weight tile (optionally transposed), then streams row
//   vectors a through a row-pipelined grid. Each result is
//   out_j = (sum_k a_k*W[k][j] + (acc_en ? c_j : 0)) mod 2^SW, masked to LOGQ
//   bits. The result appears N+1 cycles after the row handshake when there is
//   no backpressure.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, num_rows, transpose_w,  job control, latched on start in IDLE
//   acc_en
//   busy, done                     job status, one-cycle done pulse
//   w_valid/w_ready/w_data         weight beats (N per job)
//   a_valid/a_ready/a_data/c_data  row beats with accumulate vector
//   out_valid/out_ready/out_data/  result stream, out_last marks final row
//   out_last

// One output column j: psum chain over k plus the registered mask stage.
// Stage k adds a_k*W[k][j]; a_i arrives already skewed so that lane k is
// the value of the row currently sitting in stage k-1.
module mte_col #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int SW   = 16,
  parameter int LOGQ = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   adv_i,
  input  logic                   acc_en_i,
  input  logic [N-1:0][DW-1:0]   a_i,
  input  logic [N-1:0][DW-1:0]   w_i,
  input  logic [SW-1:0]          c_i,
  output logic [SW-1:0]          res_o
);
  localparam logic [SW-1:0] QMASK = {SW{1'b1}} >> (SW - LOGQ);

  logic [N-1:0][SW-1:0] psum_q;
  logic [SW-1:0]        res_q;

  // Product mod 2^SW only depends on the operands mod 2^SW, so resizing
  // both operands to SW before multiplying gives the truncated product.
  function automatic logic [SW-1:0] mulw(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [SW-1:0] ae, be;
    ae = SW'(a);
    be = SW'(b);
    return ae * be;
  endfunction

  // The accumulate term enters at stage 0 together with its row; since all
  // sums wrap, adding it first is equivalent to adding it last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psum_q <= '0;
      res_q  <= '0;
    end else if (adv_i) begin
      psum_q[0] <= (acc_en_i ? c_i : '0) + mulw(a_i[0], w_i[0]);
      for (int s = 1; s < N; s++)
        psum_q[s] <= psum_q[s-1] + mulw(a_i[s], w_i[s]);
      res_q <= psum_q[N-1] & QMASK;
    end
  end

  assign res_o = res_q;
endmodule

module mul_tile_engine #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int SW     = 16,
  parameter int LOGQ   = 15,
  parameter int ROWS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROWS_W-1:0] num_rows,
  input  logic              transpose_w,
  input  logic              acc_en,
  output logic              busy,
  output logic              done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [N*DW-1:0]   w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [N*DW-1:0]   a_data,
  input  logic [N*SW-1:0]   c_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*SW-1:0]   out_data,
  output logic              out_last
);
  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, FIN} state_e;

  state_e                       state_q, state_d;
  logic [ROWS_W-1:0]            rows_q;
  logic                         tr_q, acc_q;
  logic [CW-1:0]                wcnt_q;
  logic [ROWS_W-1:0]            acnt_q;
  logic [N-1:0][N-1:0][DW-1:0]  w_q;        // [k][j]
  logic [N:0]                   vld_pipe_q; // [s] = stage s, [N] = output
  logic [N:0]                   last_pipe_q;

  logic [N-1:0][DW-1:0] a_vec, w_vec, a_skew;
  logic [N-1:0][SW-1:0] c_vec, res;
  logic stall, adv, a_fire, w_fire, out_fire, last_row;

  assign a_vec = a_data;
  assign w_vec = w_data;
  assign c_vec = c_data;

  // Whole datapath freezes while the output register holds an unaccepted result.
  assign stall    = vld_pipe_q[N] && !out_ready;
  assign adv      = !stall;
  assign a_fire   = (state_q == RUN) && adv && a_valid;
  assign w_fire   = (state_q == LOAD_W) && w_valid;
  assign out_fire = vld_pipe_q[N] && out_ready;
  assign last_row = (acnt_q == rows_q - ROWS_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_W;
      LOAD_W:  if (w_fire && wcnt_q == CW'(N-1))
                 state_d = (rows_q != '0) ? RUN : FIN;
      RUN:     if (a_fire && last_row) state_d = DRAIN;
      DRAIN:   if (out_fire && last_pipe_q[N]) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rows_q  <= '0;
      tr_q    <= 1'b0;
      acc_q   <= 1'b0;
      wcnt_q  <= '0;
      acnt_q  <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        rows_q <= num_rows;
        tr_q   <= transpose_w;
        acc_q  <= acc_en;
        wcnt_q <= '0;
        acnt_q <= '0;
      end
      if (w_fire) begin
        wcnt_q <= wcnt_q + CW'(1);
        for (int j = 0; j < N; j++) begin
          if (tr_q) w_q[j][wcnt_q] <= w_vec[j];
          else      w_q[wcnt_q][j] <= w_vec[j];
        end
      end
      if (a_fire) acnt_q <= acnt_q + ROWS_W'(1);
    end
  end

  // Valid/last ride alongside the psum stages and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else if (adv) begin
      vld_pipe_q  <= {vld_pipe_q[N-1:0], a_fire};
      last_pipe_q <= {last_pipe_q[N-1:0], a_fire && last_row};
    end
  end

  // Input skew: lane m is delayed m advances so it meets its row at stage m.
  assign a_skew[0] = a_vec[0];
  for (genvar m = 1; m < N; m++) begin : g_skew
    logic [DW-1:0] dly_q [m];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < m; i++) dly_q[i] <= '0;
      end else if (adv) begin
        dly_q[0] <= a_vec[m];
        for (int i = 1; i < m; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign a_skew[m] = dly_q[m-1];
  end

  for (genvar j = 0; j < N; j++) begin : g_col
    logic [N-1:0][DW-1:0] w_col;
    for (genvar k = 0; k < N; k++) begin : g_w
      assign w_col[k] = w_q[k][j];
    end
    mte_col #(.N(N), .DW(DW), .SW(SW), .LOGQ(LOGQ)) u_col (
      .clk_i    (clk),
      .rst_i    (rst),
      .adv_i    (adv),
      .acc_en_i (acc_q),
      .a_i      (a_skew),
      .w_i      (w_col),
      .c_i      (c_vec[j]),
      .res_o    (res[j])
    );
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign w_ready   = (state_q == LOAD_W);
  assign a_ready   = (state_q == RUN) && !stall;
  assign out_valid = vld_pipe_q[N];
  assign out_last  = last_pipe_q[N];
  assign out_data  = res;
endmodule

// File: tb/tb_mul_tile_engine.sv
// Self-checking bench for mul_tile_engine (N=4, DW=SW=16, LOGQ=15).
module tb_mul_tile_engine;
  localparam int N = 4, DW = 16, SW = 16, LOGQ = 15, ROWS_W = 16;

  logic              clk = 0;
  logic              rst = 1;
  logic              start = 0;
  logic [ROWS_W-1:0] num_rows = '0;
  logic              transpose_w = 0, acc_en = 0;
  logic              busy, done, w_ready, a_ready, out_valid, out_last;
  logic              w_valid = 0, a_valid = 0, out_ready = 1;
  logic [N*DW-1:0]   w_data = '0, a_data = '0;
  logic [N*SW-1:0]   c_data = '0, out_data;

  mul_tile_engine #(.N(N), .DW(DW), .SW(SW), .LOGQ(LOGQ), .ROWS_W(ROWS_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .transpose_w(transpose_w), .acc_en(acc_en), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .c_data(c_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [N*SW-1:0] data; logic last; int acc_cyc; int snap; } exp_t;
  typedef struct { logic [N*SW-1:0] data; logic last; } got_t;
  exp_t exp_q[$];
  got_t got_q[$];
  int total = 0, bad = 0, cyc = 0, last_lat = 0, hold_cnt = 0;
  bit rnd_ready = 0;
  logic [N*DW-1:0] wb_arr [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Downstream ready: forced low for hold_cnt cycles, else random or always 1.
  initial forever begin
    @(posedge clk); #1;
    if (hold_cnt > 0) begin out_ready = 0; hold_cnt--; end
    else if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
    else out_ready = 1;
  end

  // Reference model + per-cycle compare.
  initial begin
    int wb, rows_seen, jrows, stall_cnt;
    bit jtr, jacc, done_exp, done_nxt, prev_stall, front_seen, stl;
    logic [DW-1:0] wm [N][N];
    exp_t e;
    longint unsigned s;
    wb = 0; rows_seen = 0; jrows = 0; stall_cnt = 0;
    jtr = 0; jacc = 0; done_exp = 0; prev_stall = 0; front_seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        wb = 0; rows_seen = 0; done_exp = 0; prev_stall = 0; front_seen = 0;
        for (int k = 0; k < N; k++) for (int j = 0; j < N; j++) wm[k][j] = '0;
      end else begin
        chk("done", 64'(done), 64'(done_exp));
        done_nxt = 0;
        if (prev_stall) chk("hold_valid", 64'(out_valid), 64'd1);
        if (out_valid) begin
          if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
          else begin
            if (!front_seen) begin
              chk("latency", 64'(cyc - exp_q[0].acc_cyc),
                  64'(N + 1 + stall_cnt - exp_q[0].snap));
              last_lat = cyc - exp_q[0].acc_cyc;
              front_seen = 1;
            end
            chk("out_data", out_data, exp_q[0].data);
            chk("out_last", 64'(out_last), 64'(exp_q[0].last));
            if (out_ready) begin
              got_q.push_back('{out_data, out_last});
              if (exp_q[0].last) done_nxt = 1;
              void'(exp_q.pop_front());
              front_seen = 0;
            end
          end
        end
        stl = out_valid && !out_ready;
        if (stl) chk("a_ready_stall", 64'(a_ready), 64'd0);
        if (w_valid && w_ready) begin
          for (int j = 0; j < N; j++) begin
            if (jtr) wm[j][wb] = w_data[j*DW +: DW];
            else     wm[wb][j] = w_data[j*DW +: DW];
          end
          wb++;
          if (wb == N) begin wb = 0; if (jrows == 0) done_nxt = 1; end
        end
        if (a_valid && a_ready) begin
          for (int j = 0; j < N; j++) begin
            s = jacc ? 64'(c_data[j*SW +: SW]) : 64'd0;
            for (int k = 0; k < N; k++)
              s += 64'(a_data[k*DW +: DW]) * 64'(wm[k][j]);
            // LOGQ <= SW, so the LOGQ-bit mask also performs the mod 2^SW.
            e.data[j*SW +: SW] = SW'(s & ((64'd1 << LOGQ) - 1));
          end
          e.last = (rows_seen == jrows - 1);
          e.acc_cyc = cyc;
          e.snap = stall_cnt;
          exp_q.push_back(e);
          rows_seen++;
        end
        if (stl) stall_cnt++;
        if (start && !busy) begin
          jrows = int'(num_rows); jtr = transpose_w; jacc = acc_en;
          wb = 0; rows_seen = 0;
        end
        done_exp = done_nxt;
        prev_stall = stl;
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic start_job(input int nr, input bit tr, input bit acc);
    start = 1; num_rows = ROWS_W'(nr); transpose_w = tr; acc_en = acc;
    tick;
    start = 0;
  endtask

  task automatic send_w(input logic [N*DW-1:0] d);
    bit hs = 0;
    w_valid = 1; w_data = d;
    for (int i = 0; i < 300 && !hs; i++) begin @(negedge clk); hs = w_ready; tick; end
    w_valid = 0;
    chk("w_handshake", 64'(hs), 64'd1);
  endtask

  task automatic load_w;
    for (int b = 0; b < N; b++) send_w(wb_arr[b]);
  endtask

  task automatic send_a(input logic [N*DW-1:0] a, input logic [N*SW-1:0] c, input int gap);
    bit hs = 0;
    repeat (gap) tick;
    a_valid = 1; a_data = a; c_data = c;
    for (int i = 0; i < 300 && !hs; i++) begin @(negedge clk); hs = a_ready; tick; end
    a_valid = 0;
    chk("a_handshake", 64'(hs), 64'd1);
  endtask

  task automatic wait_done;
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin @(negedge clk); seen = done; end
    tick;
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic set_identity;
    for (int k = 0; k < N; k++) begin
      wb_arr[k] = '0;
      wb_arr[k][k*DW +: DW] = 1;
    end
  endtask

  task automatic set_random_w;
    for (int k = 0; k < N; k++) wb_arr[k] = {$urandom, $urandom};
  endtask

  initial begin
    int nr, nlast;
    logic [N*DW-1:0] av;
    // Reset state
    tick; tick;
    @(negedge clk);
    chk("rst_ctrl", 64'({busy, done, w_ready, a_ready, out_valid, out_last}), 64'd0);
    chk("rst_data", out_data, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    tick;

    // Identity weights, single row
    set_identity; got_q.delete();
    start_job(1, 0, 0); load_w;
    send_a(64'h0004_0003_0002_0001, {$urandom, $urandom}, 0);
    wait_done;
    chk("t1_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) begin
      chk("t1_data", got_q[0].data, 64'h0004_0003_0002_0001);
      chk("t1_last", 64'(got_q[0].last), 64'd1);
    end
    chk("t1_latency", 64'(last_lat), 64'd5);

    // Orientation: beat0 = (1,2,3,4), rest zero, a = (1,0,0,0)
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < N; k++) wb_arr[k] = '0;
      wb_arr[0] = 64'h0004_0003_0002_0001;
      got_q.delete();
      start_job(1, t[0], 0); load_w;
      send_a(64'h1, 64'h0, 0);
      wait_done;
      chk("t2_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0)
        chk(t == 0 ? "t2_plain" : "t2_transposed", got_q[0].data,
            t == 0 ? 64'h0004_0003_0002_0001 : 64'h0000_0000_0000_0001);
    end

    // Accumulate wrap and LOGQ mask
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < N; k++) wb_arr[k] = '0;
      wb_arr[0] = 64'h1;
      got_q.delete();
      start_job(1, 0, t == 0);
      load_w;
      send_a(64'h7FFF, 64'h0003, 0);
      wait_done;
      chk("t3_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0)
        chk(t == 0 ? "t3_acc_mask" : "t3_noacc", got_q[0].data,
            t == 0 ? 64'h0002 : 64'h7FFF);
    end

    // Eight random rows with a 3-cycle stall after the 2nd output
    set_random_w; got_q.delete();
    start_job(8, $urandom_range(0, 1), 1); load_w;
    fork
      for (int r = 0; r < 8; r++) send_a({$urandom, $urandom}, {$urandom, $urandom}, 0);
      begin
        for (int i = 0; i < 400 && got_q.size() < 2; i++) @(negedge clk);
        hold_cnt = 3;
      end
    join
    wait_done;
    chk("t4_count", 64'(got_q.size()), 64'd8);
    nlast = 0;
    foreach (got_q[i]) nlast += int'(got_q[i].last);
    chk("t4_nlast", 64'(nlast), 64'd1);
    if (got_q.size() == 8) chk("t4_last8", 64'(got_q[7].last), 64'd1);

    // num_rows = 0, with start pulses while busy
    set_random_w; got_q.delete();
    start_job(0, 0, 0);
    start = 1; num_rows = 5;
    load_w;
    start = 0;
    wait_done;
    chk("t5_no_output", 64'(got_q.size()), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);

    // Reset with three rows in flight
    set_identity;
    start_job(6, 0, 0); load_w;
    for (int r = 0; r < 3; r++) send_a({$urandom, $urandom}, 64'h0, 0);
    rst = 1;
    tick;
    rst = 0;
    @(negedge clk);
    chk("t6_rst_ctrl", 64'({busy, done, w_ready, a_ready, out_valid, out_last}), 64'd0);
    chk("t6_rst_data", out_data, 64'd0);
    @(posedge clk); #1;
    got_q.delete();
    start_job(3, 0, 0); load_w;
    for (int r = 0; r < 3; r++) begin
      av = {$urandom, $urandom};
      send_a(av, {$urandom, $urandom}, 0);
      for (int i = 0; i < 20 && got_q.size() <= r; i++) @(negedge clk);
      @(posedge clk); #1;
      if (got_q.size() > r)
        chk("t6_identity", got_q[r].data, av & 64'h7FFF_7FFF_7FFF_7FFF);
    end
    wait_done;
    chk("t6_count", 64'(got_q.size()), 64'd3);

    // Random jobs with random backpressure and input gaps
    rnd_ready = 1;
    for (int jb = 0; jb < 5; jb++) begin
      set_random_w; got_q.delete();
      nr = $urandom_range(1, 12);
      start_job(nr, $urandom_range(0, 1), $urandom_range(0, 1)); load_w;
      for (int r = 0; r < nr; r++)
        send_a({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2));
      wait_done;
      chk("rand_count", 64'(got_q.size()), 64'(nr));
    end
    rnd_ready = 0;
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_tile_engine.md
Name: mul_tile_engine

Overview:
- Parametrised successor of the fixed 4x4 multiplier top.
- Holds an N x N weight tile, optionally loaded transposed. Streams row vectors through a weight-stationary systolic grid with internal skew/de-skew.
- Optionally adds an accumulate vector, wraps mod 2^SW and masks to LOGQ bits.
- Sits between the memory controller (weight/row/accumulate streams) and the BRAM write path. Uses valid/ready handshakes throughout.

Parameters:
- N, 4: systolic width (lanes, tile dimension), >=2
- DW, 16: input element width (a, w)
- SW, 16: accumulator/output width
- LOGQ, 15: modulus bits; output masked to LOGQ bits, LOGQ<=SW
- ROWS_W, 16: width of row-count field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle job start; sampled only in IDLE
- num_rows  in  ROWS_W  rows to stream in this job; latched on start
- transpose_w  in  1  weight load orientation; latched on start
- acc_en  in  1  add c_data to result; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle job-complete pulse
- w_valid  in  1  weight beat valid
- w_ready  out  1  weight beat accepted when w_valid&&w_ready
- w_data  in  N*DW  one weight row/column; lane j = [j*DW +: DW]
- a_valid  in  1  row beat valid
- a_ready  out  1  row beat accepted when a_valid&&a_ready
- a_data  in  N*DW  row vector a, lane k
- c_data  in  N*SW  accumulate vector; qualified by the a handshake
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  N*SW  result vector; lane j, zero-extended above LOGQ
- out_last  out  1  marks the result of the final row

Behaviour:
- Reset (rst high at a clk edge), including mid-job:
  - state -> IDLE; all weights, pipeline and counters cleared.
  - busy, done, w_ready, a_ready, out_valid, out_last = 0; out_data = 0.
- FSM states: IDLE, LOAD_W, RUN, DRAIN, FIN.
- IDLE:
  - start=1 latches num_rows, transpose_w and acc_en, then goes to LOAD_W.
  - start in any other state is ignored.
- LOAD_W:
  - w_ready=1; accepts exactly N beats; beat counter k = 0..N-1.
  - transpose_w=0: W[k][j] = lane j of beat k.
  - transpose_w=1: W[j][k] = lane j of beat k.
  - After the N-th handshake: go to RUN if num_rows!=0, else to FIN.
- RUN:
  - a_ready = !stall; accepts num_rows beats.
  - After the last accepted beat, go to DRAIN.
- DRAIN:
  - a_ready=0; wait until every in-flight result has handshaken out.
  - Then go to FIN.
- FIN:
  - done=1 for exactly one cycle, then IDLE.
  - done therefore occurs the cycle after the out_last handshake, or after the final weight handshake when num_rows=0.
- Arithmetic:
  - out_j = ( sum_{k=0..N-1} a_k*W[k][j] + (acc_en ? c_j : 0) ) mod 2^SW, then & (2^LOGQ-1).
  - Products are truncated to SW bits before accumulation; all sums wrap; unsigned.
- Latency:
  - A row accepted at cycle t yields out_valid at cycle t+N+1 when no stall occurs.
  - The delay covers N skewed grid stages plus one registered add/mask stage.
  - Results emerge in acceptance order, one per cycle at full throughput.
- Backpressure:
  - stall = out_valid && !out_ready.
  - While stall is high, the whole pipeline, skew and de-skew registers freeze and a_ready=0.
  - Holding out_data/out_valid/out_last stable while stalled is mandatory.
  - No result is lost or duplicated.
- out_last=1 exactly with the result of row num_rows-1.
- Row counter: ROWS_W bits; num_rows = 2^ROWS_W-1 must complete without wrap.
- Weights persist until the next LOAD_W or reset; a new job always reloads.

Test Plan:
- N=4, DW=SW=16, LOGQ=15, identity W, acc_en=0, num_rows=1, a=(1,2,3,4) -> out=(1,2,3,4), out_valid at accept+5, out_last=1, done next cycle after handshake.
- Beat0 = (1,2,3,4), beats1-3 = 0, a=(1,0,0,0): transpose_w=0 -> out=(1,2,3,4); transpose_w=1 -> out=(1,0,0,0).
- W[0][0]=1, a0=0x7FFF, c0=0x0003, acc_en=1 -> lane0 = 0x0002 (0x8002 masked). Same with acc_en=0 -> 0x7FFF.
- num_rows=8 with random a/W, out_ready low for 3 cycles after the 2nd output -> a_ready low during stall, 8 results match model in order, out_last only on the 8th, done one cycle after.
- num_rows=0 -> done pulses one cycle after the 4th weight handshake; out_valid never asserts; start pulses during busy are ignored.
- rst asserted in RUN with 3 rows in flight -> next cycle all outputs 0, busy=0; a following job with identity W gives correct results.
